itch_event_queue: RTL

Parametrised event collector behind the ITCH decoder bank. It captures the one-cycle `*_internal_valid` pulses and their field payloads from NUM_CH decoders and tags each captured event with its channel index and a sequence number. Events are buffered in a DEPTH-entry FIFO and presented downstream as a single valid/ready stream. It also reports decoder collisions and overflow drops, so the single-issue decoders can feed a back-pressured order-book stage.

---
 rtl/itch_event_queue.sv | 136 +++++++++++++
 1 files changed

// File: rtl/itch_event_queue.sv
// Collects one-cycle event pulses from the ITCH decoder bank and tags each event with its channel and a sequence number.
// Accepted events are queued in a FIFO and leave on one registered valid/ready stream. Drops and collisions are counted.
module itch_event_queue #(
    parameter int NUM_CH    = 6,
    parameter int PAYLOAD_W = 256,
    parameter int DEPTH     = 8,
    parameter int SEQ_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             ch_valid,
    input  logic [NUM_CH*PAYLOAD_W-1:0]   ch_payload,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2:0]                    out_tag,
    output logic [SEQ_W-1:0]              out_seq,
    output logic [PAYLOAD_W-1:0]          out_payload,
    output logic [$clog2(DEPTH):0]        fifo_count,
    output logic                          overflow,
    output logic [15:0]                   drop_count,
    output logic [15:0]                   collision_count
);

    localparam int AW      = $clog2(DEPTH);
    localparam int PTR_W   = AW + 1;
    localparam int ENTRY_W = 3 + SEQ_W + PAYLOAD_W;

    logic [PAYLOAD_W-1:0] ch_pay_arr [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign ch_pay_arr[gi] = ch_payload[gi*PAYLOAD_W +: PAYLOAD_W];
        end
    endgenerate

    logic                 cand_valid;
    logic [2:0]           cand_tag;
    logic [PAYLOAD_W-1:0] cand_payload;
    logic                 collision;

    // Scanning from the top down leaves the lowest-index asserted channel as the winner.
    always_comb begin
        cand_valid   = |ch_valid;
        cand_tag     = 3'd0;
        cand_payload = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_valid[i]) begin
                cand_tag     = 3'(i);
                cand_payload = ch_pay_arr[i];
            end
        end
    end

    assign collision = (ch_valid & (ch_valid - NUM_CH'(1))) != '0;

    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W-1:0]   wr_ptr_next, rd_ptr_next;
    logic [SEQ_W-1:0]   seq_ctr_reg;
    logic [ENTRY_W-1:0] head_reg, head_next;
    logic               head_load;
    logic               overflow_reg;
    logic [15:0]        drop_count_reg, collision_count_reg;
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic fifo_empty, fifo_full, deq, enq, drop;
    logic [ENTRY_W-1:0] new_entry;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign deq        = !fifo_empty && out_ready;
    assign enq        = cand_valid && (!fifo_full || deq);
    assign drop       = cand_valid && fifo_full && !deq;
    assign new_entry  = {cand_tag, seq_ctr_reg, cand_payload};

    assign wr_ptr_next = wr_ptr_reg + PTR_W'(enq);
    assign rd_ptr_next = rd_ptr_reg + PTR_W'(deq);

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr_reg[AW-1:0]] <= new_entry;
        end
    end

    // The head register preloads the next entry. When that entry is the one being
    // written this cycle, it takes the incoming event directly.
    always_comb begin
        head_load = 1'b1;
        head_next = mem[rd_ptr_next[AW-1:0]];
        if (rd_ptr_next == wr_ptr_reg) begin
            head_load = enq;
            head_next = new_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg          <= '0;
            rd_ptr_reg          <= '0;
            seq_ctr_reg         <= '0;
            head_reg            <= '0;
            overflow_reg        <= 1'b0;
            drop_count_reg      <= '0;
            collision_count_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            if (enq) begin
                seq_ctr_reg <= seq_ctr_reg + SEQ_W'(1);
            end
            if (head_load) begin
                head_reg <= head_next;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
                if (drop_count_reg != 16'hFFFF) begin
                    drop_count_reg <= drop_count_reg + 16'd1;
                end
            end
            if (collision && collision_count_reg != 16'hFFFF) begin
                collision_count_reg <= collision_count_reg + 16'd1;
            end
        end
    end

    assign out_valid       = !fifo_empty;
    assign out_tag         = head_reg[ENTRY_W-1 -: 3];
    assign out_seq         = head_reg[PAYLOAD_W +: SEQ_W];
    assign out_payload     = head_reg[PAYLOAD_W-1:0];
    assign fifo_count      = wr_ptr_reg - rd_ptr_reg;
    assign overflow        = overflow_reg;
    assign drop_count      = drop_count_reg;
    assign collision_count = collision_count_reg;

endmodule
